// File: rtl/ep_bulk_out_nyet.sv
// USB bulk OUT end-point: toggle/length checks, commit/rollback FIFO, frame re-assembly, AXI-S sink.
// Define BULK_OUT_PING_EN for the HS build (PING tokens answered, NYET issued when nearly full).
module ep_bulk_out_nyet #(
    parameter int unsigned MAX_PACKET_LENGTH = 512,
    parameter int unsigned FIFO_DEPTH        = 2048,
    parameter bit          ENABLED           = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          set_conf_i,
    input  logic                          clr_conf_i,
    input  logic                          set_halt_i,
    input  logic                          clr_halt_i,
    input  logic                          selected_i,
    input  logic                          rx_ping_i,
    input  logic                          rx_parity_i,
    input  logic                          rx_done_i,
    input  logic                          rx_error_i,
    input  logic                          hsk_sent_i,
    input  logic                          s_tvalid,
    input  logic                          s_tkeep,
    input  logic                          s_tlast,
    output logic                          s_tready,
    input  logic [7:0]                    s_tdata,
    output logic                          hsk_valid_o,
    output logic [1:0]                    hsk_pid_o,
    output logic                          stalled_o,
    output logic                          parity_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [7:0]                    m_tdata
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(MAX_PACKET_LENGTH) + 1;

    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] MPL_P   = PW'(MAX_PACKET_LENGTH);
    localparam logic [CW-1:0] MPL_C   = CW'(MAX_PACKET_LENGTH);

    localparam logic [1:0] PID_ACK   = 2'd0;
    localparam logic [1:0] PID_NAK   = 2'd1;
    localparam logic [1:0] PID_STALL = 2'd3;
`ifdef BULK_OUT_PING_EN
    localparam logic [1:0] PID_NYET  = 2'd2;
`endif

    typedef enum logic [2:0] {
        ST_HALT,
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            parity_q, parity_d;
    logic            rx_par_q, rx_par_d;
    logic            frame_open_q, frame_open_d;
    logic            tlast_seen_q, tlast_seen_d;
    logic            hsk_valid_q, hsk_valid_d;
    logic [1:0]      hsk_pid_q, hsk_pid_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tlast_q, m_tlast_d;
    logic [7:0]      m_tdata_q, m_tdata_d;
    logic [PW-1:0]   level_q, level_d;
    logic            s_tready_q, s_tready_d;
    logic            stalled_q, stalled_d;

    logic [7:0]      mem_data [FIFO_DEPTH];
    logic            mem_last [FIFO_DEPTH];

    logic            data_we_c;
    logic            last_we_c;
    logic [AW-1:0]   last_addr_c;
    logic            last_val_c;

    logic [PW-1:0]   free_c;
    logic            room_c;
    logic [PW-1:0]   limit_c;
    logic [AW-1:0]   rd_addr_c;
    logic [AW-1:0]   wr_m1_c;
    logic [AW-1:0]   cm_m1_c;
    logic            beat_c;
    logic            halt_req_c;

    assign free_c     = DEPTH_P - (wr_ptr_q - rd_ptr_q);
    assign room_c     = (free_c >= MPL_P);
    // While a frame is open its final byte is withheld until its tlast is known.
    assign limit_c    = frame_open_q ? (cm_ptr_q - PW'(1)) : cm_ptr_q;
    assign rd_addr_c  = rd_ptr_q[AW-1:0];
    assign wr_m1_c    = wr_ptr_q[AW-1:0] - AW'(1);
    assign cm_m1_c    = cm_ptr_q[AW-1:0] - AW'(1);
    assign beat_c     = s_tvalid && s_tkeep && !tlast_seen_q;
    assign halt_req_c = set_halt_i || clr_conf_i || !ENABLED;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HALT;
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            parity_q     <= 1'b0;
            rx_par_q     <= 1'b0;
            frame_open_q <= 1'b0;
            tlast_seen_q <= 1'b0;
            hsk_valid_q  <= 1'b0;
            hsk_pid_q    <= 2'd0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tdata_q    <= 8'd0;
            level_q      <= '0;
            s_tready_q   <= 1'b0;
            stalled_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            parity_q     <= parity_d;
            rx_par_q     <= rx_par_d;
            frame_open_q <= frame_open_d;
            tlast_seen_q <= tlast_seen_d;
            hsk_valid_q  <= hsk_valid_d;
            hsk_pid_q    <= hsk_pid_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            m_tdata_q    <= m_tdata_d;
            level_q      <= level_d;
            s_tready_q   <= s_tready_d;
            stalled_q    <= stalled_d;
        end
    end

    // Packet RAM; tlast bits have their own write enable so a patch leaves the data intact.
    always_ff @(posedge clock) begin
        if (data_we_c) begin
            mem_data[wr_ptr_q[AW-1:0]] <= s_tdata;
        end
        if (last_we_c) begin
            mem_last[last_addr_c] <= last_val_c;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cm_ptr_d     = cm_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        parity_d     = parity_q;
        rx_par_d     = rx_par_q;
        frame_open_d = frame_open_q;
        tlast_seen_d = tlast_seen_q;
        hsk_valid_d  = hsk_valid_q;
        hsk_pid_d    = hsk_pid_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        m_tdata_d    = m_tdata_q;
        data_we_c    = 1'b0;
        last_we_c    = 1'b0;
        last_addr_c  = wr_ptr_q[AW-1:0];
        last_val_c   = 1'b0;

        // Output register doubles as the RAM read stage: refill whenever empty or consumed.
        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end
        if ((!m_tvalid_q || m_tready) && (rd_ptr_q != limit_c)) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = mem_data[rd_addr_c];
            m_tlast_d  = mem_last[rd_addr_c];
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end

        if (hsk_sent_i) begin
            hsk_valid_d = 1'b0;
        end

        case (state_q)
            ST_HALT: begin
                if (selected_i || rx_ping_i) begin
                    hsk_valid_d = 1'b1;
                    hsk_pid_d   = PID_STALL;
                end
                if (set_conf_i || clr_halt_i) begin
                    state_d  = ST_IDLE;
                    parity_d = 1'b0;
                end
                if (set_conf_i) begin
                    wr_ptr_d     = '0;
                    cm_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    frame_open_d = 1'b0;
                    m_tvalid_d   = 1'b0;
                    m_tlast_d    = 1'b0;
                    m_tdata_d    = 8'd0;
                end
            end
            ST_IDLE: begin
                if (selected_i) begin
                    if (room_c) begin
                        state_d      = ST_RECV;
                        cnt_d        = '0;
                        tlast_seen_d = 1'b0;
                    end else begin
                        state_d     = ST_RESP;
                        hsk_valid_d = 1'b1;
                        hsk_pid_d   = PID_NAK;
                    end
                end
`ifdef BULK_OUT_PING_EN
                else if (rx_ping_i) begin
                    state_d     = ST_RESP;
                    hsk_valid_d = 1'b1;
                    hsk_pid_d   = room_c ? PID_ACK : PID_NAK;
                end
`endif
            end
            ST_RECV: begin
                if (rx_error_i || (beat_c && (cnt_q == MPL_C))) begin
                    // CRC error or babble: drop the speculative bytes silently.
                    wr_ptr_d = cm_ptr_q;
                    state_d  = ST_IDLE;
                end else begin
                    if (beat_c) begin
                        data_we_c    = 1'b1;
                        last_we_c    = 1'b1;
                        wr_ptr_d     = wr_ptr_q + PW'(1);
                        cnt_d        = cnt_q + CW'(1);
                        tlast_seen_d = s_tlast;
                    end
                    if (rx_done_i) begin
                        state_d  = ST_CHECK;
                        rx_par_d = rx_parity_i;
                    end
                end
            end
            ST_CHECK: begin
                state_d     = ST_RESP;
                hsk_valid_d = 1'b1;
                hsk_pid_d   = PID_ACK;
                if (rx_par_q != parity_q) begin
                    wr_ptr_d = cm_ptr_q;
                end else begin
                    cm_ptr_d = wr_ptr_q;
                    parity_d = ~parity_q;
                    if (cnt_q == '0) begin
                        if (frame_open_q) begin
                            last_we_c   = 1'b1;
                            last_addr_c = cm_m1_c;
                            last_val_c  = 1'b1;
                        end
                        frame_open_d = 1'b0;
                    end else if (cnt_q < MPL_C) begin
                        last_we_c    = 1'b1;
                        last_addr_c  = wr_m1_c;
                        last_val_c   = 1'b1;
                        frame_open_d = 1'b0;
                    end else begin
                        frame_open_d = 1'b1;
                    end
`ifdef BULK_OUT_PING_EN
                    if (!room_c) begin
                        hsk_pid_d = PID_NYET;
                    end
`endif
                end
            end
            ST_RESP: begin
                if (hsk_sent_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Halt entry discards any in-flight packet and any handshake not yet requested.
        if (halt_req_c) begin
            state_d = ST_HALT;
            if (state_q != ST_HALT) begin
                wr_ptr_d     = cm_ptr_q;
                cm_ptr_d     = cm_ptr_q;
                parity_d     = parity_q;
                frame_open_d = frame_open_q;
                data_we_c    = 1'b0;
                last_we_c    = 1'b0;
                hsk_valid_d  = hsk_valid_q && !hsk_sent_i;
                hsk_pid_d    = hsk_pid_q;
            end
        end

        level_d    = cm_ptr_d - rd_ptr_d;
        s_tready_d = (state_d == ST_RECV);
        stalled_d  = (state_d == ST_HALT);
    end

    assign s_tready    = s_tready_q;
    assign hsk_valid_o = hsk_valid_q;
    assign hsk_pid_o   = hsk_pid_q;
    assign stalled_o   = stalled_q;
    assign parity_o    = parity_q;
    assign level_o     = level_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tlast     = m_tlast_q;
    assign m_tdata     = m_tdata_q;

endmodule

// File: tb/tb_ep_bulk_out_nyet.sv
// Directed bench for ep_bulk_out_nyet: decoder/controller driver and sink scoreboard.
module tb_ep_bulk_out_nyet;

    localparam int MPL = 512;
    localparam int ACK = 0, NAK = 1, NYET = 2, STALL = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        set_conf_i = 1'b0, clr_conf_i = 1'b0, set_halt_i = 1'b0, clr_halt_i = 1'b0;
    logic        selected_i = 1'b0, rx_ping_i = 1'b0, rx_parity_i = 1'b0;
    logic        rx_done_i = 1'b0, rx_error_i = 1'b0, hsk_sent_i = 1'b0;
    logic        s_tvalid = 1'b0, s_tkeep = 1'b0, s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  s_tdata = 8'd0;
    logic        hsk_valid_o;
    logic [1:0]  hsk_pid_o;
    logic        stalled_o, parity_o;
    logic [11:0] level_o;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic [7:0]  m_tdata;

    ep_bulk_out_nyet dut (
        .clock(clock), .reset(reset),
        .set_conf_i(set_conf_i), .clr_conf_i(clr_conf_i),
        .set_halt_i(set_halt_i), .clr_halt_i(clr_halt_i),
        .selected_i(selected_i), .rx_ping_i(rx_ping_i), .rx_parity_i(rx_parity_i),
        .rx_done_i(rx_done_i), .rx_error_i(rx_error_i), .hsk_sent_i(hsk_sent_i),
        .s_tvalid(s_tvalid), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tready(s_tready), .s_tdata(s_tdata),
        .hsk_valid_o(hsk_valid_o), .hsk_pid_o(hsk_pid_o),
        .stalled_o(stalled_o), .parity_o(parity_o), .level_o(level_o),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready), .m_tdata(m_tdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];
    bit model_open = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sink monitor: a beat seen valid&ready here transfers on the next rising edge.
    always @(negedge clock) begin
        if (!reset && m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_out(input bit par, input int len, input int start,
                            input int err_at, input int halt_at);
        selected_i = 1'b1;
        tick();
        selected_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == err_at) begin
                s_tvalid   = 1'b0;
                rx_error_i = 1'b1;
                tick();
                rx_error_i = 1'b0;
                return;
            end
            s_tvalid   = 1'b1;
            s_tkeep    = 1'b1;
            s_tdata    = 8'(start + i);
            s_tlast    = (i == len - 1);
            set_halt_i = (i == halt_at);
            tick();
        end
        s_tvalid    = 1'b0;
        s_tkeep     = 1'b0;
        s_tlast     = 1'b0;
        set_halt_i  = 1'b0;
        rx_done_i   = 1'b1;
        rx_parity_i = par;
        tick();
        rx_done_i   = 1'b0;
    endtask

    task automatic send_ping();
        rx_ping_i = 1'b1;
        tick();
        rx_ping_i = 1'b0;
    endtask

    task automatic wait_hsk(input int pid, input string tag);
        int n = 0;
        while (!hsk_valid_o && n < 50) begin
            tick();
            n++;
        end
        if (!hsk_valid_o) begin
            check_eq({tag, " hsk_valid"}, 0, 1);
        end else begin
            check_eq({tag, " hsk_pid"}, int'(hsk_pid_o), pid);
            hsk_sent_i = 1'b1;
            tick();
            hsk_sent_i = 1'b0;
            tick();
        end
    endtask

    task automatic no_hsk(input string tag);
        bit seen = 1'b0;
        repeat (20) begin
            tick();
            if (hsk_valid_o) seen = 1'b1;
        end
        check_eq({tag, " no_hsk"}, int'(seen), 0);
    endtask

    task automatic push_pkt(input int len, input int start);
        for (int i = 0; i < len; i++) begin
            logic [8:0] e;
            e = {1'b0, 8'(start + i)};
            if (i == len - 1 && len < MPL) e[8] = 1'b1;
            exp_q.push_back(e);
        end
        if (len == MPL) begin
            model_open = 1'b1;
        end else begin
            if (len == 0 && model_open && exp_q.size() > 0)
                exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] | 9'h100;
            model_open = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        int bad = 0;
        while (rx_q.size() < exp_q.size() && n < 5000) begin
            tick();
            n++;
        end
        repeat (10) tick();
        check_eq({tag, " beats"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) bad++;
        check_eq({tag, " data"}, bad, 0);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_beats(input int cnt);
        int n = 0;
        while (rx_q.size() < cnt && n < 5000) begin
            tick();
            n++;
        end
        repeat (20) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_eq("rst stalled", int'(stalled_o), 1);
        check_eq("rst parity", int'(parity_o), 0);
        check_eq("rst hsk_valid", int'(hsk_valid_o), 0);
        check_eq("rst m_tvalid", int'(m_tvalid), 0);
        check_eq("rst level", int'(level_o), 0);
        check_eq("rst s_tready", int'(s_tready), 0);

        // OUT while halted
        send_out(1'b0, 8, 0, -1, -1);
        wait_hsk(STALL, "halt out");

        set_conf_i = 1'b1; tick(); set_conf_i = 1'b0; tick();
        check_eq("conf stalled", int'(stalled_o), 0);
        check_eq("conf parity", int'(parity_o), 0);

        // Single short packet
        send_out(1'b0, 100, 0, -1, -1);
        wait_hsk(ACK, "p100");
        check_eq("p100 parity", int'(parity_o), 1);
        push_pkt(100, 0);
        drain("p100");
        check_eq("p100 level", int'(level_o), 0);

        // Two full packets then ZDP: final byte withheld until the ZDP
        send_out(1'b1, 512, 0, -1, -1);
        wait_hsk(ACK, "full1");
        push_pkt(512, 0);
        send_out(1'b0, 512, 8'h55, -1, -1);
        wait_hsk(ACK, "full2");
        push_pkt(512, 8'h55);
        wait_beats(1024);
        check_eq("withheld beats", rx_q.size(), 1023);
        send_out(1'b1, 0, 0, -1, -1);
        wait_hsk(ACK, "zdp");
        push_pkt(0, 0);
        drain("frame1024");
        check_eq("zdp parity", int'(parity_o), 0);

        // Duplicate DATA0
        send_out(1'b0, 10, 8'h80, -1, -1);
        wait_hsk(ACK, "dup first");
        push_pkt(10, 8'h80);
        send_out(1'b0, 10, 8'h80, -1, -1);
        wait_hsk(ACK, "dup repeat");
        check_eq("dup parity", int'(parity_o), 1);
        drain("dup");

        // CRC error mid-packet, then retry
        send_out(1'b1, 200, 8'h10, 150, -1);
        no_hsk("crc err");
        check_eq("crc level", int'(level_o), 0);
        check_eq("crc parity", int'(parity_o), 1);
        send_out(1'b1, 200, 8'h10, -1, -1);
        wait_hsk(ACK, "retry");
        push_pkt(200, 8'h10);
        drain("retry");
        check_eq("retry parity", int'(parity_o), 0);

        // Babble: one byte over max packet length
        send_out(1'b0, 513, 0, -1, -1);
        no_hsk("babble");
        check_eq("babble parity", int'(parity_o), 0);
        check_eq("babble beats", rx_q.size(), 0);
        check_eq("babble level", int'(level_o), 0);

        // Fill the FIFO with the sink stalled
        m_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_out(1'(k), 512, k * 16, -1, -1);
`ifdef BULK_OUT_PING_EN
            wait_hsk((k == 3) ? NYET : ACK, "fill");
`else
            wait_hsk(ACK, "fill");
`endif
            push_pkt(512, k * 16);
        end
        send_out(1'b0, 10, 0, -1, -1);
        wait_hsk(NAK, "full nak");
        check_eq("full parity", int'(parity_o), 0);
        check_eq("full level", int'(level_o >= 12'd2047), 1);
        send_ping();
`ifdef BULK_OUT_PING_EN
        wait_hsk(NAK, "full ping");
`else
        no_hsk("ping ignored");
`endif
        m_tready = 1'b1;
        wait_beats(2048);
        check_eq("fill withheld", rx_q.size(), 2047);
        send_out(1'b0, 0, 0, -1, -1);
        wait_hsk(ACK, "fill zdp");
        push_pkt(0, 0);
        drain("fill");
        check_eq("fill parity", int'(parity_o), 1);
`ifdef BULK_OUT_PING_EN
        send_ping();
        wait_hsk(ACK, "drained ping");
`endif

        // Halt during reception
        send_out(1'b1, 100, 0, -1, 50);
        check_eq("halt stalled", int'(stalled_o), 1);
        send_out(1'b1, 5, 0, -1, -1);
        wait_hsk(STALL, "halted out");
        check_eq("halt level", int'(level_o), 0);
        check_eq("halt beats", rx_q.size(), 0);
        clr_halt_i = 1'b1; tick(); clr_halt_i = 1'b0; tick();
        check_eq("clr_halt parity", int'(parity_o), 0);
        check_eq("clr_halt stalled", int'(stalled_o), 0);
        send_out(1'b0, 20, 8'h40, -1, -1);
        wait_hsk(ACK, "after halt");
        push_pkt(20, 8'h40);
        drain("after halt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
